ip_checksum_stream: RTL and testbench

Streaming, parametrised successor to the fixed 160-bit IPv4 header checksum block. It accumulates the RFC 1071 16-bit one's-complement sum over an AXI-Stream packet of any length, with a configurable bus width. It supports odd-byte tails via tkeep and an optional pseudo-header seed, and delivers one 16-bit checksum per packet on an output handshake. It sits beside framers and deframers (IPv4 header, UDP, ICMP) to generate or verify checksums on the fly.

---
 rtl/ip_checksum_stream.sv | 111 +++++++++++
 tb/tb_ip_checksum_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_checksum_stream.sv
// Streaming RFC 1071 one's-complement checksum over an AXI-Stream packet.
// Produces one 16-bit result per packet on an output handshake.
module ip_checksum_stream #(
   parameter int WIDTH    = 64,
   parameter bit INVERT   = 1'b1,
   parameter bit ZERO_SUB = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic [15:0]        i_seed,
   input  logic [WIDTH-1:0]   i_tdata,
   input  logic [WIDTH/8-1:0] i_tkeep,
   input  logic               i_tlast,
   input  logic               i_tvalid,
   output logic               i_tready,
   output logic [15:0]        o_tdata,
   output logic               o_tvalid,
   input  logic               o_tready
);

   localparam int LANES = WIDTH / 16;
   localparam int LSW   = 16 + $clog2(LANES) + 1;

   typedef enum logic [1:0] {IDLE, ACCUM, FOLD, HOLD} state_t;

   state_t            state, state_n;
   logic [31:0]       acc, acc_n, base, acc_sum;
   logic [15:0]       res_n, s2, r_inv, r_fin;
   logic              vld_n, beat;
   logic [16:0]       s1, part;
   logic [WIDTH-1:0]  data_m;
   logic [LSW-1:0]    lanesum;

   assign i_tready = (state == IDLE) || (state == ACCUM);
   assign beat     = i_tvalid && i_tready;

   // Byte k of the bus pairs with keep bit k, so masking is a straight per-byte select.
   always_comb begin
      data_m = i_tdata;
      for (int k = 0; k < WIDTH / 8; k++) begin
         if (i_tlast && !i_tkeep[k]) data_m[8*k +: 8] = 8'h00;
      end
   end

   always_comb begin
      lanesum = '0;
      for (int l = 0; l < LANES; l++) begin
         lanesum = lanesum + LSW'(data_m[16*l +: 16]);
      end
   end

   // Folding the running sum on every beat keeps acc bounded for any packet length.
   assign part    = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
   assign base    = (state == IDLE) ? {16'h0000, i_seed} : {15'h0000, part};
   assign acc_sum = base + 32'(lanesum);

   assign s1    = part;
   assign s2    = s1[15:0] + {15'h0000, s1[16]};
   assign r_inv = INVERT ? ~s2 : s2;
   assign r_fin = (ZERO_SUB && (r_inv == 16'h0000)) ? 16'hFFFF : r_inv;

   always_comb begin
      state_n = state;
      acc_n   = acc;
      res_n   = o_tdata;
      vld_n   = o_tvalid;
      case (state)
         IDLE, ACCUM: begin
            if (beat) begin
               acc_n   = acc_sum;
               state_n = i_tlast ? FOLD : ACCUM;
            end
         end
         FOLD: begin
            res_n   = r_fin;
            vld_n   = 1'b1;
            state_n = HOLD;
         end
         HOLD: begin
            if (o_tready) begin
               vld_n   = 1'b0;
               acc_n   = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         acc      <= '0;
         o_tdata  <= '0;
         o_tvalid <= 1'b0;
      end else if (clear) begin
         state    <= IDLE;
         acc      <= '0;
         o_tdata  <= '0;
         o_tvalid <= 1'b0;
      end else begin
         state    <= state_n;
         acc      <= acc_n;
         o_tdata  <= res_n;
         o_tvalid <= vld_n;
      end
   end

endmodule

// File: tb/tb_ip_checksum_stream.sv
// Bench for ip_checksum_stream: five configurations share one 64-bit stimulus bus
// (narrow ones see its top slice) and are checked against a byte-level RFC 1071 model.
module tb_ip_checksum_stream;

   logic        clk = 1'b0;
   logic        reset, clear, i_tlast, i_tvalid, o_tready;
   logic [15:0] i_seed;
   logic [63:0] i_tdata;
   logic [7:0]  i_tkeep;
   logic        itr [5];
   logic        ov  [5];
   logic [15:0] ot  [5];

   int w_of   [5] = '{64, 32, 16, 16, 64};
   bit inv_of [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   bit zs_of  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] pkt[$];
   logic [7:0]  pkt_keep;
   logic [15:0] pkt_seed;
   logic [15:0] got  [5];
   logic [15:0] exp_a[5];

   always #5 clk = ~clk;

   ip_checksum_stream #(.WIDTH(64), .INVERT(1'b1), .ZERO_SUB(1'b0)) u_d64 (
      .clk(clk), .reset(reset), .clear(clear), .i_seed(i_seed), .i_tdata(i_tdata),
      .i_tkeep(i_tkeep), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(itr[0]),
      .o_tdata(ot[0]), .o_tvalid(ov[0]), .o_tready(o_tready));
   ip_checksum_stream #(.WIDTH(32), .INVERT(1'b1), .ZERO_SUB(1'b0)) u_d32 (
      .clk(clk), .reset(reset), .clear(clear), .i_seed(i_seed), .i_tdata(i_tdata[63:32]),
      .i_tkeep(i_tkeep[7:4]), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(itr[1]),
      .o_tdata(ot[1]), .o_tvalid(ov[1]), .o_tready(o_tready));
   ip_checksum_stream #(.WIDTH(16), .INVERT(1'b1), .ZERO_SUB(1'b0)) u_d16 (
      .clk(clk), .reset(reset), .clear(clear), .i_seed(i_seed), .i_tdata(i_tdata[63:48]),
      .i_tkeep(i_tkeep[7:6]), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(itr[2]),
      .o_tdata(ot[2]), .o_tvalid(ov[2]), .o_tready(o_tready));
   ip_checksum_stream #(.WIDTH(16), .INVERT(1'b1), .ZERO_SUB(1'b1)) u_d16z (
      .clk(clk), .reset(reset), .clear(clear), .i_seed(i_seed), .i_tdata(i_tdata[63:48]),
      .i_tkeep(i_tkeep[7:6]), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(itr[3]),
      .o_tdata(ot[3]), .o_tvalid(ov[3]), .o_tready(o_tready));
   ip_checksum_stream #(.WIDTH(64), .INVERT(1'b0), .ZERO_SUB(1'b0)) u_d64r (
      .clk(clk), .reset(reset), .clear(clear), .i_seed(i_seed), .i_tdata(i_tdata),
      .i_tkeep(i_tkeep), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(itr[4]),
      .o_tdata(ot[4]), .o_tvalid(ov[4]), .o_tready(o_tready));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Reference: the packet as a byte stream, bytes paired big-endian, summed and folded.
   function automatic logic [15:0] model(input int w, input bit inv, input bit zs);
      longint unsigned s;
      logic [7:0]      v;
      logic [15:0]     res;
      s = 64'(pkt_seed);
      for (int i = 0; i < pkt.size(); i++) begin
         for (int b = 0; b < w / 8; b++) begin
            v = pkt[i][63-8*b -: 8];
            if (i == pkt.size() - 1 && !pkt_keep[7-b]) v = 8'h00;
            s += (b % 2 == 0) ? (64'(v) << 8) : 64'(v);
         end
      end
      while (s > 64'hFFFF) s = (s & 64'hFFFF) + (s >> 16);
      res = inv ? ~s[15:0] : s[15:0];
      if (zs && res == 16'h0000) res = 16'hFFFF;
      return res;
   endfunction

   task automatic send_pkt(input int abort_after, input bit bubbles);
      int n;
      for (int i = 0; i < pkt.size(); i++) begin
         if (i == abort_after) begin
            i_tvalid = 1'b0;
            clear    = 1'b1;
            tick();
            clear    = 1'b0;
            return;
         end
         if (bubbles && $urandom_range(0, 3) == 0) begin
            i_tvalid = 1'b0;
            i_tdata  = {$urandom, $urandom};
            i_tlast  = 1'($urandom);
            tick();
         end
         i_tvalid = 1'b1;
         i_tdata  = pkt[i];
         i_tlast  = (i == pkt.size() - 1);
         i_tkeep  = i_tlast ? pkt_keep : 8'($urandom);
         i_seed   = (i == 0) ? pkt_seed : 16'($urandom);
         n = 0;
         while (!itr[0] && n < 50) begin
            tick();
            n++;
         end
         check("rdy_wait", 32'(itr[0]), 32'd1);
         tick();
      end
      i_tvalid = 1'b0;
      i_tlast  = 1'b0;
   endtask

   // Entered right after the edge that accepted the tlast beat.
   task automatic recv_pkt(input int hold);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("fold_rdy%0d", k), 32'(itr[k]), 32'd0);
         check($sformatf("fold_vld%0d", k), 32'(ov[k]), 32'd0);
      end
      tick();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("vld%0d", k), 32'(ov[k]), 32'd1);
         got[k] = ot[k];
         check($sformatf("sum%0d", k), 32'(ot[k]), 32'(model(w_of[k], inv_of[k], zs_of[k])));
      end
      repeat (hold) begin
         tick();
         check("hold_stable", {15'h0, ov[0], ot[0]}, {15'h0, 1'b1, got[0]});
      end
      o_tready = 1'b1;
      tick();
      o_tready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("post_vld%0d", k), 32'(ov[k]), 32'd0);
         check($sformatf("post_rdy%0d", k), 32'(itr[k]), 32'd1);
      end
   endtask

   task automatic load_case1;
      pkt = {64'h4500_0030_4422_4000, 64'h8006_0000_8c7c_19ac, 64'hae24_1e2b_dead_beef};
      pkt_keep = 8'hF0;
      pkt_seed = 16'h0000;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0; o_tready = 1'b0;
      i_tdata = '0; i_tkeep = '0; i_seed = '0;
      repeat (3) tick();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("rst_vld%0d", k), 32'(ov[k]), 32'd0);
         check($sformatf("rst_data%0d", k), 32'(ot[k]), 32'd0);
      end
      reset = 1'b0;
      tick();
      check("rst_rdy", 32'(itr[0]), 32'd1);

      // IPv4 header with a 4-byte tail.
      load_case1();
      send_pkt(-1, 1'b0);
      recv_pkt(0);
      check("ipv4_442e", 32'(got[0]), 32'h442e);
      check("ipv4_raw", 32'(got[4]), 32'hBBD1);

      // End-around carry on a 16-bit bus.
      pkt = {64'hFFFF_0000_0000_0000, 64'h0001_0000_0000_0000};
      pkt_keep = 8'hFF; pkt_seed = 16'h0000;
      send_pkt(-1, 1'b0);
      recv_pkt(1);
      check("carry_fffe", 32'(got[2]), 32'hFFFE);

      // Seed plus zero substitution, single beat.
      pkt = {64'hFFFE_0000_0000_0000};
      pkt_keep = 8'hFF; pkt_seed = 16'h0001;
      send_pkt(-1, 1'b0);
      recv_pkt(0);
      check("zero_nosub", 32'(got[2]), 32'h0000);
      check("zero_sub", 32'(got[3]), 32'hFFFF);

      // Odd length on a 32-bit bus.
      pkt = {64'h0102_0304_0000_0000, 64'h0506_AABB_0000_0000};
      pkt_keep = 8'h80; pkt_seed = 16'h0000;
      send_pkt(-1, 1'b0);
      recv_pkt(0);
      check("odd_f6f9", 32'(got[1]), 32'hF6F9);

      // All-zero keep on the last beat contributes nothing.
      pkt = {64'h1234_5678_9abc_def0, 64'hFFFF_FFFF_FFFF_FFFF};
      pkt_keep = 8'h00; pkt_seed = 16'h1111;
      send_pkt(-1, 1'b1);
      recv_pkt(2);

      // Randomized packets with bubbles and output stalls.
      for (int p = 0; p < 40; p++) begin
         pkt.delete();
         repeat ($urandom_range(1, 6)) pkt.push_back({$urandom, $urandom});
         pkt_keep = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         pkt_seed = 16'($urandom);
         send_pkt(-1, 1'b1);
         recv_pkt($urandom_range(0, 3));
      end

      // Backpressure with the next packet already waiting.
      pkt = {64'hA5A5_5A5A_0F0F_F0F0, 64'h1357_9BDF_2468_ACE0};
      pkt_keep = 8'hFE; pkt_seed = 16'h0BAD;
      send_pkt(-1, 1'b0);
      for (int k = 0; k < 5; k++) exp_a[k] = model(w_of[k], inv_of[k], zs_of[k]);
      pkt = {64'hCAFE_BABE_0000_0001};
      pkt_keep = 8'hFF; pkt_seed = 16'h7777;
      i_tvalid = 1'b1; i_tdata = pkt[0]; i_tlast = 1'b1; i_tkeep = pkt_keep; i_seed = pkt_seed;
      tick();
      for (int k = 0; k < 5; k++) check($sformatf("bp_sum%0d", k), 32'(ot[k]), 32'(exp_a[k]));
      for (int c = 0; c < 10; c++) begin
         check("bp_rdy", 32'(itr[0]), 32'd0);
         check("bp_stable", {15'h0, ov[0], ot[0]}, {15'h0, 1'b1, exp_a[0]});
         tick();
      end
      o_tready = 1'b1;
      tick();
      o_tready = 1'b0;
      check("bp_rdy_after", 32'(itr[0]), 32'd1);
      check("bp_vld_after", 32'(ov[0]), 32'd0);
      tick();
      i_tvalid = 1'b0; i_tlast = 1'b0;
      recv_pkt(0);

      // Clear mid-packet: no result, then a clean packet.
      load_case1();
      send_pkt(2, 1'b0);
      repeat (4) begin
         check("clr_no_vld", 32'(ov[0]), 32'd0);
         check("clr_rdy", 32'(itr[0]), 32'd1);
         tick();
      end
      load_case1();
      send_pkt(-1, 1'b0);
      recv_pkt(0);
      check("clr_then_442e", 32'(got[0]), 32'h442e);

      // Clear while a result is held.
      send_pkt(-1, 1'b0);
      tick();
      check("hold_vld", 32'(ov[0]), 32'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("clr_hold_vld%0d", k), 32'(ov[k]), 32'd0);
         check($sformatf("clr_hold_data%0d", k), 32'(ot[k]), 32'd0);
      end

      // Asynchronous reset in the middle of a cycle while holding a result.
      send_pkt(-1, 1'b0);
      tick();
      check("ar_hold_vld", 32'(ov[0]), 32'd1);
      #2 reset = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("ar_vld%0d", k), 32'(ov[k]), 32'd0);
         check($sformatf("ar_data%0d", k), 32'(ot[k]), 32'd0);
      end
      tick();
      reset = 1'b0;
      repeat (3) begin
         tick();
         check("ar_no_pulse", 32'(ov[0]), 32'd0);
         check("ar_rdy", 32'(itr[0]), 32'd1);
      end
      load_case1();
      send_pkt(-1, 1'b1);
      recv_pkt(1);
      check("ar_then_442e", 32'(got[0]), 32'h442e);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
